// File: rtl/multiple_transfer_ctrl_pkg.sv
// ============================================================================
// Module   : multiple_transfer_ctrl_pkg
// Brief    : Shared state encodings, register numbers and index mapping for
//            the Thumb block-transfer sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multiple_transfer_ctrl_pkg;

  typedef enum logic [1:0] {
    MT_IDLE  = 2'd0,
    MT_XFER  = 2'd1,
    MT_DRAIN = 2'd2,
    MT_WB    = 2'd3
  } mt_state_e;

  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  // List bit 8 names LR on stores and PC on loads.
  function automatic logic [3:0] map_idx(input logic [3:0] bit_idx, input logic is_load);
    if (bit_idx == 4'd8) begin
      return is_load ? REG_PC : REG_LR;
    end
    return bit_idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multiple_transfer_ctrl_reg_list_scan.sv
// ============================================================================
// Module   : reg_list_scan
// Brief    : Lowest-set-bit index, any flag and popcount over a 9-bit list.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_list_scan (
  input  logic [8:0] list_i,
  output logic [3:0] idx_o,
  output logic       any_o,
  output logic [3:0] count_o
);

  always_comb begin
    idx_o   = 4'd0;
    count_o = 4'd0;
    any_o   = |list_i;
    for (int i = 8; i >= 0; i--) begin
      if (list_i[i]) begin
        idx_o = 4'(i);
      end
    end
    for (int i = 0; i < 9; i++) begin
      count_o = count_o + {3'd0, list_i[i]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/multiple_transfer_ctrl.sv
// ============================================================================
// Module   : multiple_transfer_ctrl
// Brief    : LDM/STM/PUSH/POP sequencer: one memory access per cycle, loaded
//            words and the updated base go to the write-back mux.
//            Option MULT_POP_PC_EN: loads of list bit 8 write PC (pc_load).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiple_transfer_ctrl
  import multiple_transfer_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_push,
  input  logic [8:0]  reg_list,
  input  logic [3:0]  base_idx,
  input  logic [31:0] base_addr,
  input  logic        wback_req,
  input  logic [31:0] reg_rdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_addr,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  reg_rd_idx,
  output logic        w_reg_en_from_multiple,
  output logic [3:0]  w_reg_idx,
  output logic [31:0] Ri,
  output logic        pc_load
);

  mt_state_e   state_q;
  logic        busy_q;
  logic        done_q;
  logic [8:0]  list_q;
  logic        is_load_q;
  logic        wb_en_q;
  logic [3:0]  base_idx_q;
  logic [31:0] new_base_q;
  logic [31:0] next_addr_q;
  logic [31:0] mem_addr_q;
  logic        mem_ren_q;
  logic        mem_wen_q;
  logic [3:0]  cur_idx_q;
  logic        ld_wr_q;
  logic        wb_q;
  logic [3:0]  w_reg_idx_q;
  logic        ld_pc_q;

  logic [8:0]  eff_list_d;
  logic [8:0]  scan_list_d;
  logic [3:0]  scan_idx;
  logic        scan_any;
  logic [3:0]  scan_cnt;
  logic [8:0]  low_bit_d;
  logic [31:0] four_n_d;
  logic        push_d;
  logic [31:0] start_addr_d;
  logic [31:0] new_base_d;
  logic        wb_apply_d;

`ifdef MULT_POP_PC_EN
  assign eff_list_d = reg_list;
`else
  assign eff_list_d = is_load ? {1'b0, reg_list[7:0]} : reg_list;
`endif

  // In IDLE the scanner looks at the incoming list, otherwise at what remains.
  assign scan_list_d = (state_q == MT_IDLE) ? eff_list_d : list_q;

  reg_list_scan u_scan (
    .list_i  (scan_list_d),
    .idx_o   (scan_idx),
    .any_o   (scan_any),
    .count_o (scan_cnt)
  );

  assign low_bit_d    = 9'd1 << scan_idx;
  assign four_n_d     = {26'd0, scan_cnt, 2'b00};
  assign push_d       = is_push & ~is_load;
  assign start_addr_d = push_d ? (base_addr - four_n_d) : base_addr;
  assign new_base_d   = push_d ? (base_addr - four_n_d) : (base_addr + four_n_d);
  assign wb_apply_d   = wback_req & ~(is_load & ~base_idx[3] & eff_list_d[base_idx[2:0]]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MT_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      list_q      <= 9'd0;
      is_load_q   <= 1'b0;
      wb_en_q     <= 1'b0;
      base_idx_q  <= 4'd0;
      new_base_q  <= 32'd0;
      next_addr_q <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      cur_idx_q   <= 4'd0;
      ld_wr_q     <= 1'b0;
      wb_q        <= 1'b0;
      w_reg_idx_q <= 4'd0;
      ld_pc_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MT_IDLE: begin
          ld_wr_q     <= 1'b0;
          ld_pc_q     <= 1'b0;
          wb_q        <= 1'b0;
          w_reg_idx_q <= 4'd0;
          if (start) begin
            is_load_q  <= is_load;
            base_idx_q <= base_idx;
            wb_en_q    <= wb_apply_d;
            new_base_q <= new_base_d;
            if (scan_any) begin
              state_q     <= MT_XFER;
              busy_q      <= 1'b1;
              mem_addr_q  <= start_addr_d;
              next_addr_q <= start_addr_d + 32'd4;
              mem_ren_q   <= is_load;
              mem_wen_q   <= ~is_load;
              cur_idx_q   <= map_idx(scan_idx, is_load);
              list_q      <= scan_list_d & ~low_bit_d;
            end else begin
              done_q <= 1'b1;
            end
          end
        end

        MT_XFER: begin
          // The access issued this cycle returns its load data next cycle.
          ld_wr_q     <= is_load_q;
          ld_pc_q     <= is_load_q & (cur_idx_q == REG_PC);
          w_reg_idx_q <= is_load_q ? cur_idx_q : 4'd0;
          if (scan_any) begin
            mem_addr_q  <= next_addr_q;
            next_addr_q <= next_addr_q + 32'd4;
            cur_idx_q   <= map_idx(scan_idx, is_load_q);
            list_q      <= scan_list_d & ~low_bit_d;
          end else begin
            mem_addr_q <= 32'd0;
            mem_ren_q  <= 1'b0;
            mem_wen_q  <= 1'b0;
            cur_idx_q  <= 4'd0;
            if (is_load_q) begin
              state_q <= MT_DRAIN;
            end else if (wb_en_q) begin
              state_q     <= MT_WB;
              wb_q        <= 1'b1;
              w_reg_idx_q <= base_idx_q;
            end else begin
              state_q <= MT_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        MT_DRAIN: begin
          ld_wr_q <= 1'b0;
          ld_pc_q <= 1'b0;
          if (wb_en_q) begin
            state_q     <= MT_WB;
            wb_q        <= 1'b1;
            w_reg_idx_q <= base_idx_q;
          end else begin
            state_q     <= MT_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            w_reg_idx_q <= 4'd0;
          end
        end

        MT_WB: begin
          state_q     <= MT_IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          wb_q        <= 1'b0;
          w_reg_idx_q <= 4'd0;
        end

        default: begin
          state_q <= MT_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy                   = busy_q;
  assign done                   = done_q;
  assign mem_addr               = mem_addr_q;
  assign mem_ren                = mem_ren_q;
  assign mem_wen                = mem_wen_q;
  assign mem_wdata              = mem_wen_q ? reg_rdata : 32'd0;
  assign reg_rd_idx             = cur_idx_q;
  assign w_reg_en_from_multiple = ld_wr_q | wb_q;
  assign w_reg_idx              = w_reg_idx_q;

`ifdef MULT_POP_PC_EN
  assign pc_load = ld_wr_q & ld_pc_q;
  assign Ri      = ld_wr_q ? (ld_pc_q ? {mem_rdata[31:1], 1'b0} : mem_rdata)
                 : (wb_q ? new_base_q : 32'd0);
`else
  logic unused_pc;
  assign unused_pc = ld_pc_q;
  assign pc_load   = 1'b0;
  assign Ri        = ld_wr_q ? mem_rdata : (wb_q ? new_base_q : 32'd0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_multiple_transfer_ctrl.sv
// ============================================================================
// Module   : tb_multiple_transfer_ctrl
// Brief    : Directed and random block transfers checked against a
//            cycle-numbered reference model of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiple_transfer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_load;
  logic        is_push;
  logic [8:0]  reg_list;
  logic [3:0]  base_idx;
  logic [31:0] base_addr;
  logic        wback_req;
  logic [31:0] reg_rdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] mem_addr;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  reg_rd_idx;
  logic        w_reg_en_from_multiple;
  logic [3:0]  w_reg_idx;
  logic [31:0] Ri;
  logic        pc_load;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] salt     = 32'h1234_5678;
  bit          use_force = 1'b0;
  logic [31:0] mem_force = 32'd0;

  multiple_transfer_ctrl dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .is_load                (is_load),
    .is_push                (is_push),
    .reg_list               (reg_list),
    .base_idx               (base_idx),
    .base_addr              (base_addr),
    .wback_req              (wback_req),
    .reg_rdata              (reg_rdata),
    .mem_rdata              (mem_rdata),
    .busy                   (busy),
    .done                   (done),
    .mem_addr               (mem_addr),
    .mem_ren                (mem_ren),
    .mem_wen                (mem_wen),
    .mem_wdata              (mem_wdata),
    .reg_rd_idx             (reg_rd_idx),
    .w_reg_en_from_multiple (w_reg_en_from_multiple),
    .w_reg_idx              (w_reg_idx),
    .Ri                     (Ri),
    .pc_load                (pc_load)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rf_fn(input logic [3:0] idx);
    return 32'hBEEF_0000 | (32'(idx) * 32'h0000_0111);
  endfunction

  assign reg_rdata = rf_fn(reg_rd_idx);

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (use_force) return mem_force;
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  function automatic logic [3:0] mapi(input int b, input bit ld);
    if (b == 8) return ld ? 4'd15 : 4'd14;
    return 4'(b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_xfer(input bit ld, input bit ps, input logic [8:0] lst,
                          input logic [3:0] bi, input logic [31:0] ba,
                          input bit wbr, input bit spur);
    int          bits[$];
    int          n;
    int          last;
    int          wbcyc;
    logic [8:0]  eff;
    logic [31:0] sa;
    logic [31:0] nb;
    logic [31:0] prev_addr;
    logic [31:0] ri_e;
    logic [3:0]  idx_e;
    bit          wbx;
    bit          acc;
    bit          ldw;
    bit          wbc;
    bit          pc_e;

    eff = lst;
`ifndef MULT_POP_PC_EN
    if (ld) eff[8] = 1'b0;
`endif
    for (int i = 0; i < 9; i++) if (eff[i]) bits.push_back(i);
    n     = bits.size();
    sa    = (ps && !ld) ? ba - 32'(4 * n) : ba;
    nb    = (ps && !ld) ? ba - 32'(4 * n) : ba + 32'(4 * n);
    wbx   = wbr && !(ld && bi < 4'd8 && eff[bi[2:0]]);
    last  = (n == 0) ? 0 : (ld ? n + 1 + int'(wbx) : n + int'(wbx));
    wbcyc = ld ? n + 2 : n + 1;

    start = 1'b1; is_load = ld; is_push = ps; reg_list = lst;
    base_idx = bi; base_addr = ba; wback_req = wbr;
    prev_addr = 32'd0;
    for (int c = 1; c <= last + 2; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 1'b0;
      if (spur && c == 2) start = 1'b1;
      if (spur && c == 3) start = 1'b0;
      mem_rdata = mem_fn(prev_addr);
      #1;
      acc = (n > 0) && (c <= n);
      ldw = ld && (n > 0) && (c >= 2) && (c <= n + 1);
      wbc = wbx && (n > 0) && (c == wbcyc);
      chk("busy", 32'(busy), 32'((c >= 1) && (c <= last)));
      chk("done", 32'(done), 32'(c == last + 1));
      chk("mem_ren", 32'(mem_ren), 32'(acc && ld));
      chk("mem_wen", 32'(mem_wen), 32'(acc && !ld));
      if (acc) begin
        chk("mem_addr", mem_addr, sa + 32'(4 * (c - 1)));
        if (!ld) begin
          chk("reg_rd_idx", 32'(reg_rd_idx), 32'(mapi(bits[c-1], 1'b0)));
          chk("mem_wdata", mem_wdata, rf_fn(mapi(bits[c-1], 1'b0)));
        end
      end
      ri_e = 32'd0; idx_e = 4'd0; pc_e = 1'b0;
      if (ldw) begin
        idx_e = mapi(bits[c-2], 1'b1);
        ri_e  = mem_fn(sa + 32'(4 * (c - 2)));
        if (idx_e == 4'd15) begin
          ri_e[0] = 1'b0;
          pc_e    = 1'b1;
        end
      end else if (wbc) begin
        idx_e = bi;
        ri_e  = nb;
      end
      chk("w_reg_en", 32'(w_reg_en_from_multiple), 32'(ldw || wbc));
      if (ldw || wbc) chk("w_reg_idx", 32'(w_reg_idx), 32'(idx_e));
      chk("Ri", Ri, ri_e);
      chk("pc_load", 32'(pc_load), 32'(pc_e));
      prev_addr = mem_addr;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_push = 1'b0; reg_list = 9'd0;
    base_idx = 4'd0; base_addr = 32'd0; wback_req = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ren", 32'(mem_ren), 32'd0);
    chk("rst_wen", 32'(mem_wen), 32'd0);
    chk("rst_wen_mult", 32'(w_reg_en_from_multiple), 32'd0);
    chk("rst_pc_load", 32'(pc_load), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_Ri", Ri, 32'd0);
    chk("rst_widx", 32'(w_reg_idx), 32'd0);
    chk("rst_ridx", 32'(reg_rd_idx), 32'd0);
    rst = 1'b0;

    // Directed cases from the block's use scenarios
    run_xfer(1'b1, 1'b0, 9'h00B, 4'd4,  32'h0000_0100, 1'b1, 1'b0);
    run_xfer(1'b0, 1'b1, 9'h103, 4'd13, 32'h0000_0200, 1'b1, 1'b0);
    run_xfer(1'b1, 1'b0, 9'h002, 4'd1,  32'h0000_0300, 1'b1, 1'b0);
    run_xfer(1'b1, 1'b0, 9'h000, 4'd2,  32'h0000_0400, 1'b1, 1'b0);
    use_force = 1'b1; mem_force = 32'h0000_0301;
    run_xfer(1'b1, 1'b0, 9'h100, 4'd13, 32'h0000_0500, 1'b1, 1'b0);
    use_force = 1'b0;
    run_xfer(1'b1, 1'b0, 9'h00F, 4'd9,  32'hFFFF_FFF8, 1'b1, 1'b0);
    run_xfer(1'b0, 1'b0, 9'h0F0, 4'd2,  32'h0000_0040, 1'b0, 1'b1);
    run_xfer(1'b1, 1'b0, 9'h1FF, 4'd13, 32'h0000_0800, 1'b1, 1'b1);

    // Reset landing in cycle 2 of a four-register STM
    start = 1'b1; is_load = 1'b0; is_push = 1'b0; reg_list = 9'h00F;
    base_idx = 4'd2; base_addr = 32'h0000_0600; wback_req = 1'b1;
    @(posedge clk); #1 start = 1'b0; #1;
    chk("rstmid_c1_wen", 32'(mem_wen), 32'd1);
    @(posedge clk); #1 rst = 1'b1; #1;
    chk("rstmid_c2_wen", 32'(mem_wen), 32'd1);
    @(posedge clk); #1 rst = 1'b0; #1;
    chk("rstmid_c3_busy", 32'(busy), 32'd0);
    chk("rstmid_c3_done", 32'(done), 32'd0);
    chk("rstmid_c3_wen", 32'(mem_wen), 32'd0);
    chk("rstmid_c3_ren", 32'(mem_ren), 32'd0);
    chk("rstmid_c3_wmult", 32'(w_reg_en_from_multiple), 32'd0);
    @(posedge clk); #2;
    chk("rstmid_c4_done", 32'(done), 32'd0);
    chk("rstmid_c4_busy", 32'(busy), 32'd0);

    // Random transactions
    for (int t = 0; t < 40; t++) begin
      logic [8:0]  l;
      logic [31:0] b;
      salt = $urandom;
      l    = 9'($urandom);
      if (t % 7 == 0) l = 9'd0;
      b    = $urandom & 32'hFFFF_FFFC;
      run_xfer(1'($urandom), 1'($urandom), l, 4'($urandom), b,
               1'($urandom), ($countones(l) >= 3) ? 1'($urandom) : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
